counter_event_monitor: RTL

//  Downstream observer of the up/down loadable counter. Samples the counter value
//  and its control inputs every CLK, then classifies each transition as wrap-up,

---
 rtl/counter_mon_pkg.sv | 19 +
 rtl/counter_event_monitor_if.sv | 31 +++
 rtl/mon_event_fifo.sv | 57 +++++
 rtl/counter_event_monitor.sv | 130 +++++++++++++
 4 files changed

// File: rtl/counter_mon_pkg.sv
// Shared event types and record layout for the counter event monitor.
package counter_mon_pkg;

  typedef enum logic [1:0] {
    EV_WRAP_UP = 2'd0,
    EV_WRAP_DN = 2'd1,
    EV_CLEAR   = 2'd2,
    EV_JUMP    = 2'd3
  } ev_type_e;

  localparam int unsigned EvTypeW = 2;

  // Packed record layout, MSB first: {type, value, time}.
  function automatic int unsigned rec_width(input int unsigned bit_width,
                                            input int unsigned ts_w);
    return EvTypeW + bit_width + ts_w;
  endfunction

endpackage

// File: rtl/counter_event_monitor_if.sv
// Event stream from the monitor to its consumer: valid/ready plus the head record.
interface counter_event_monitor_if
  import counter_mon_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 4,
  parameter int unsigned TS_W      = 16
) ();

  logic                 ev_valid;
  logic                 ev_ready;
  ev_type_e             ev_type;
  logic [BIT_WIDTH-1:0] ev_value;
  logic [TS_W-1:0]      ev_time;

  modport master (
    output ev_valid,
    output ev_type,
    output ev_value,
    output ev_time,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_type,
    input  ev_value,
    input  ev_time,
    output ev_ready
  );

endinterface

// File: rtl/mon_event_fifo.sv
// Generic first-word-fall-through FIFO over registered storage; Depth must be a power of 2.
module mon_event_fifo #(
  parameter int unsigned Width = 22,
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CntW-1:0]  o_count
);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CntW'(Depth));
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];

  // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

endmodule

// File: rtl/counter_event_monitor.sv
// Watches an up/down loadable counter, classifies unexpected or wrapping transitions
// and queues timestamped event records for a valid/ready consumer.
module counter_event_monitor
  import counter_mon_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 4,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned TS_W      = 16,
  parameter int unsigned DROP_W    = 8
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   mon_en,
  input  logic [BIT_WIDTH-1:0]   cnt_in,
  input  logic                   dir_in,
  input  logic                   clr_in,
  counter_event_monitor_if.master ev_if,
  output logic [DROP_W-1:0]      drop_cnt,
  output logic                   overflow
);

  localparam int unsigned RecW = rec_width(BIT_WIDTH, TS_W);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [BIT_WIDTH-1:0] MaxVal = '1;

  logic [TS_W-1:0]      r_ts;
  logic [BIT_WIDTH-1:0] r_prev;
  logic                 r_prev_dir;
  logic                 r_prev_clr;
  logic                 r_prev_valid;
  logic [DROP_W-1:0]    r_drop_cnt;
  logic                 r_overflow;

  logic [BIT_WIDTH-1:0] w_exp;
  logic                 w_ev_det;
  ev_type_e             w_ev_type;
  logic [RecW-1:0]      w_push_data;
  logic [RecW-1:0]      w_head;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_drop;
  logic [CntW-1:0]      w_count;
  logic                 w_unused_count;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_ts         <= '0;
      r_prev       <= '0;
      r_prev_dir   <= 1'b0;
      r_prev_clr   <= 1'b0;
      r_prev_valid <= 1'b0;
    end else begin
      r_ts <= r_ts + 1'b1;
      if (mon_en) begin
        r_prev       <= cnt_in;
        r_prev_dir   <= dir_in;
        r_prev_clr   <= clr_in;
        r_prev_valid <= 1'b1;
      end else begin
        r_prev_valid <= 1'b0;
      end
    end
  end

  // A mismatch against the natural next value means a load overrode the count.
  always_comb begin
    w_exp     = r_prev_clr ? '0 : (r_prev_dir ? r_prev + 1'b1 : r_prev - 1'b1);
    w_ev_det  = 1'b0;
    w_ev_type = EV_JUMP;
    if (mon_en && r_prev_valid) begin
      if (cnt_in != w_exp) begin
        w_ev_det  = 1'b1;
        w_ev_type = EV_JUMP;
      end else if (r_prev_clr && (r_prev != '0)) begin
        w_ev_det  = 1'b1;
        w_ev_type = EV_CLEAR;
      end else if (!r_prev_clr && r_prev_dir && (r_prev == MaxVal)) begin
        w_ev_det  = 1'b1;
        w_ev_type = EV_WRAP_UP;
      end else if (!r_prev_clr && !r_prev_dir && (r_prev == '0)) begin
        w_ev_det  = 1'b1;
        w_ev_type = EV_WRAP_DN;
      end
    end
  end

  assign w_push_data = {w_ev_type, cnt_in, r_ts};
  assign w_pop       = ~w_empty & ev_if.ev_ready;
  assign w_drop      = w_ev_det & w_full & ~w_pop;

  mon_event_fifo #(
    .Width (RecW),
    .Depth (DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (reset),
    .i_push  (w_ev_det),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_unused_count = ^w_count;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != '1) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  assign drop_cnt = r_drop_cnt;
  assign overflow = r_overflow;

  // Record fields read as zero whenever nothing is queued.
  assign ev_if.ev_valid = ~w_empty;
  assign ev_if.ev_type  = w_empty ? EV_WRAP_UP : ev_type_e'(w_head[RecW-1 -: EvTypeW]);
  assign ev_if.ev_value = w_empty ? '0 : w_head[TS_W +: BIT_WIDTH];
  assign ev_if.ev_time  = w_empty ? '0 : w_head[TS_W-1:0];

endmodule
